// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma modulator and its decimator.
package dsm_pkg;

  localparam int DSM_VIN_W = 20;
  localparam int DSM_DECIM = 50;

  // Minimum CIC register width: each order adds log2(decim) bits of gain.
  // The extra 2 bits cover the sign and the +/-1 input.
  function automatic int cic_acc_w(input int decim, input int order);
    return order * $clog2(decim) + 2;
  endfunction

endpackage

// File: rtl/dsm_cic_integrator.sv
// One CIC integrator stage: a modular accumulator that holds when en is low.
module dsm_cic_integrator
  import dsm_pkg::*;
#(
  parameter int W = DSM_VIN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  // Wrap-around is intentional: the comb differences cancel it.
  always_ff @(posedge clock) begin
    if (!reset)  acc <= '0;
    else if (en) acc <= acc + din;
  end

endmodule

// File: rtl/dsm_cic_decim.sv
// Third-order CIC decimator for the 1-bit modulator stream, with a
// one-entry valid/ready output register and a sticky overrun flag.
module dsm_cic_decim
  import dsm_pkg::*;
#(
  parameter int DECIM = DSM_DECIM,
  parameter int ACC_W = DSM_VIN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm,
  output logic [ACC_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam int PH_W = $clog2(DECIM);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  if (DECIM < 2 || DECIM > 64) begin : g_bad_decim
    $error("dsm_cic_decim: DECIM must be 2..64");
  end
  if (ACC_W < cic_acc_w(DECIM, 3)) begin : g_bad_acc_w
    $error("dsm_cic_decim: ACC_W too narrow for DECIM");
  end

  // +1 / -1 input sample, sign-extended.
  logic [ACC_W-1:0] x;
  assign x = pwm ? ACC_W'(1) : '1;

  // Integrator cascade: each stage accumulates the previous stage's register.
  logic [2:0][ACC_W-1:0] stg_in, acc;
  assign stg_in[0] = x;
  assign stg_in[1] = acc[0];
  assign stg_in[2] = acc[1];

  for (genvar s = 0; s < 3; s++) begin : g_int
    dsm_cic_integrator #(.W(ACC_W)) u_int (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .din   (stg_in[s]),
      .acc   (acc[s])
    );
  end

  // The comb sees i3 as updated on this edge. That lines the zeroed comb
  // history up with the zeroed integrator history, so the first window
  // kept after settling is already exact.
  logic [ACC_W-1:0] i3_upd;
  assign i3_upd = acc[2] + acc[1];

  logic [PH_W-1:0] phase;
  logic [1:0]      settle;
  logic            tick, sample_ok;

  assign tick      = en && (phase == PH_LAST);
  assign sample_ok = tick && (settle == 2'd2);

  // Phase counter: counts enabled cycles modulo DECIM.
  always_ff @(posedge clock) begin
    if (!reset)  phase <= '0;
    else if (en) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
  end

  // Settle counter: the first two ticks only prime the comb delays.
  always_ff @(posedge clock) begin
    if (!reset)                        settle <= '0;
    else if (tick && settle != 2'd2)   settle <= settle + 2'd1;
  end

  // Comb chain is combinational within the tick cycle.
  logic [ACC_W-1:0] d1, d2, d3, c1, c2, c3;
  assign c1 = i3_upd - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  // Comb delay registers advance once per tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (tick) begin
      d1 <= i3_upd;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Output holding register: a new sample wins over a same-cycle handshake;
  // overwriting an unconsumed sample latches overrun until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (sample_ok) begin
      dout       <= c3;
      dout_valid <= 1'b1;
      if (dout_valid && !dout_ready) overrun <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: doc/dsm_cic_decim.md
# dsm_cic_decim

Third-order CIC (sinc3) decimator that sits directly downstream of `dsm_top`. It consumes the 1-bit `pwm` stream at the fast modulator clock and reconstructs a 20-bit signed sample every `DECIM` clocks, which is the slow input-sample rate. It is the on-chip loopback and monitor path for the modulator: verification compares its output against the stimulus `vin`, and the block also drives the in-system level monitor. Output uses a valid/ready handshake with a one-entry holding register and a sticky overrun flag.

## Interface
- `DECIM`, default 50: clocks per output sample; must be 2..64.
- `ACC_W`, default 20: integrator, comb and output width; must be at least 3*ceil(log2(DECIM))+2.
- `clock` in 1: modulator clock.
- `reset` in 1: reset, synchronous, active-low.
- `en` in 1: processing enable; when 0, integrators, counter and combs hold.
- `pwm` in 1: modulator bit; 1 maps to +1, 0 maps to -1.
- `dout` out ACC_W: signed decimated sample.
- `dout_valid` out 1: `dout` holds an unconsumed sample.
- `dout_ready` in 1: consumer accepts `dout` on a cycle when `dout_valid` is also 1.
- `overrun` out 1: sticky; set when a sample was overwritten before it was consumed.

## Operation
- Reset (`reset`=0 at a clock edge): all integrators, comb delays, the phase counter and the settle counter go to 0; `dout`=0, `dout_valid`=0, `overrun`=0. Reset asserted mid-window discards the partial window. No output is produced until the next full window.
- Integrators: three cascaded accumulators, registered and pipelined.
  - i1 += x, where x is ±1 sign-extended to ACC_W.
  - i2 += i1 (registered value).
  - i3 += i2.
  - All arithmetic is modular two's complement. Wrap-around is legal and required; no saturation anywhere.
- Phase counter runs 0..DECIM-1 while `en`=1 and wraps to 0. A tick is a cycle where the counter is DECIM-1 and `en`=1.
- Combs run only on a tick, in three stages.
  - c1 = i3 - d1, then d1 <= i3.
  - c2 = c1 - d2, then d2 <= c1.
  - c3 = c2 - d3, then d3 <= c2.
  - The stages are combinational within the tick cycle, with a registered result.
- Settling: the results of the first 2 ticks after reset are discarded (settle counter 0..2, saturating). Every later tick produces a sample.
- Output register:
  - A produced sample is written to `dout` and sets `dout_valid`.
  - A handshake (`dout_valid`=1 and `dout_ready`=1) clears `dout_valid` unless a new sample arrives on the same cycle. In that case `dout` takes the new sample, `dout_valid` stays 1 and `overrun` is not set.
  - If a sample arrives while `dout_valid`=1 and `dout_ready`=0, `dout` is overwritten and `overrun` is set.
  - `overrun` clears only on reset.
- Gain is DECIM^3. Full-scale output is ±DECIM^3, which is ±125000 at the defaults.

## Timing
- `pwm` is sampled at each rising edge of `clock`. Path latency from `pwm` to i3 is 3 cycles.
- On a tick edge, `dout` and `dout_valid` update. `dout` is visible the cycle after the tick.
- Output spacing is exactly DECIM cycles when `en` stays 1. An `en`=0 cycle stretches the spacing by one cycle.
- `dout_ready` is combinationally unused: there is no ready-to-valid path, and `dout_valid` never depends on `dout_ready` in the same cycle.
- `dout` stays stable while `dout_valid`=1, except for the overwrite case, which is flagged by `overrun`.

## Structure
- Shared package `dsm_pkg` holds:
  - constants `DSM_VIN_W`=20 and `DSM_DECIM`=50;
  - function `cic_acc_w(decim, order)` for the width check.
- Sub-module `dsm_cic_integrator` holds one accumulator stage (width parameter, `en`, modular add) and is instantiated 3 times.
- The comb stages, counter and output register live in the top-level module.

## Test plan
- Constant `pwm`=1 from reset release, `dout_ready`=1: the first delivered sample is at tick 3, and every sample is +125000. The run lasts at least 200 samples so that the i3 wrap is exercised.
- Constant `pwm`=0: every delivered sample is -125000.
- Alternating 1,0,1,0…: every delivered sample is 0.
- Hold `dout_ready`=0 across 2 ticks after the first valid sample: `overrun`=1, `dout` equals the newest sample, and `dout_valid` stays 1 until ready is asserted.
- Assert `reset`=0 mid-window for 1 cycle, then apply `pwm`=1: there is no output for the next 2 ticks, the third tick gives +125000, and `overrun` and `dout_valid` are 0 after reset.
- Toggle `en`=0 for 7 cycles within a window under constant `pwm`=1: the output value is unchanged (+125000) and sample spacing is DECIM+7 cycles for that window.
